// File: rtl/mix_columns_iter.sv
// AES MixColumns stage: mixes COLS_PER_CYCLE columns per clock behind valid/ready handshakes.
// Optional InvMixColumns mode (and port in_inverse) enabled by defining INV_MIX_COLUMNS_EN.
module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
`ifdef INV_MIX_COLUMNS_EN
  input  logic         in_inverse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int unsigned SH       = (COLS_PER_CYCLE == 4) ? 2 : (COLS_PER_CYCLE == 2) ? 1 : 0;
  localparam int unsigned NGROUPS  = 4 >> SH;
  localparam logic [1:0]  LAST_CNT = 2'(NGROUPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] wr;
  logic [1:0]   cnt;
  logic [1:0]   base;
  logic         accept;
  logic [1:0]   col_idx [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];
`ifdef INV_MIX_COLUMNS_EN
  logic         inv_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = c;
    return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
  endfunction

`ifdef INV_MIX_COLUMNS_EN
  // 9/B/D/E multiples built from x, 2x, 4x, 8x
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = c;
    return {gmul(a0, 4'hB) ^ gmul(a1, 4'hD) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'hE),
            gmul(a0, 4'hD) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'hE) ^ gmul(a3, 4'hB),
            gmul(a0, 4'h9) ^ gmul(a1, 4'hE) ^ gmul(a2, 4'hB) ^ gmul(a3, 4'hD),
            gmul(a0, 4'hE) ^ gmul(a1, 4'hB) ^ gmul(a2, 4'hD) ^ gmul(a3, 4'h9)};
  endfunction
`endif

  assign accept    = in_valid && in_ready;
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = wr;
  assign base      = cnt << SH;

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_idx[g] = base + 2'(g);
`ifdef INV_MIX_COLUMNS_EN
      assign col_out[g] = inv_q ? inv_mix(wr[32*col_idx[g] +: 32])
                                : fwd_mix(wr[32*col_idx[g] +: 32]);
`else
      assign col_out[g] = fwd_mix(wr[32*col_idx[g] +: 32]);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = in_bypass ? DONE : BUSY;
      BUSY: if (cnt == LAST_CNT) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr  <= '0;
      cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
      inv_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        wr  <= in_data;
        cnt <= '0;
`ifdef INV_MIX_COLUMNS_EN
        inv_q <= in_inverse;
`endif
      end else if (state == BUSY) begin
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
          wr[32*col_idx[g] +: 32] <= col_out[g];
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2, 4 (three instances sharing inputs).
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_ready;
`ifdef INV_MIX_COLUMNS_EN
  logic         in_inverse;
`endif
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];
  int           lat [3];
  int           checks = 0;
  int           failures = 0;
  int           exp_lat [3] = '{5, 3, 2};

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_bypass(in_bypass),
`ifdef INV_MIX_COLUMNS_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_bypass(in_bypass),
`ifdef INV_MIX_COLUMNS_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_bypass(in_bypass),
`ifdef INV_MIX_COLUMNS_EN
    .in_inverse(in_inverse),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));

  task automatic chk(input string tag, input int inst, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  // Accept one state into all instances, then record per-instance cycles to out_valid (0 = timeout).
  task automatic run(input logic [127:0] d, input logic byp, input logic inv);
    for (int i = 0; i < 3; i++) chk("pre_ready", i, 128'(ir[i]), 128'd1);
    in_data = d;
    in_bypass = byp;
`ifdef INV_MIX_COLUMNS_EN
    in_inverse = inv;
`else
    if (inv) $display("note: inverse request ignored in forward-only build");
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < 3; i++) if (ov[i] && lat[i] == 0) lat[i] = c;
      if (ov[0] && ov[1] && ov[2]) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [127:0] exp, input logic byp);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_lat"}, i, 128'(lat[i]), byp ? 128'd1 : 128'(exp_lat[i]));
      chk({tag, "_data"}, i, od[i], exp);
    end
  endtask

  localparam logic [127:0] V1_IN  = {96'h0, 32'h455313DB};
  localparam logic [127:0] V1_OUT = {96'h0, 32'hBCA14D8E};
  localparam logic [127:0] V2_IN  = 128'h4c31262d_c6c6c6c6_01010101_5c220af2;
  localparam logic [127:0] V2_OUT = 128'hf8bd7e4d_c6c6c6c6_01010101_9d58dc9f;
  localparam logic [127:0] BYP    = 128'h0123456789abcdef_fedcba9876543210;

  initial begin
    logic [127:0] x, y;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_EN
    in_inverse = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, 128'(ir[i]), 128'd0);
      chk("rst_valid", i, 128'(ov[i]), 128'd0);
      chk("rst_data", i, od[i], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(V1_IN, 1'b0, 1'b0);
    check_result("single_col", V1_OUT, 1'b0);
    release_out();
    for (int i = 0; i < 3; i++) chk("idle_after", i, 128'(ov[i]), 128'd0);

    run(V2_IN, 1'b0, 1'b0);
    check_result("four_col", V2_OUT, 1'b0);
    release_out();

    // bypass, then hold in DONE under backpressure with noisy input
    run(BYP, 1'b1, 1'b0);
    check_result("bypass", BYP, 1'b1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk("bp_data", i, od[i], BYP);
        chk("bp_valid", i, 128'(ov[i]), 128'd1);
        chk("bp_ready", i, 128'(ir[i]), 128'd0);
      end
    end
    in_valid = 1'b0;
    release_out();
    for (int i = 0; i < 3; i++) begin
      chk("pulse_valid", i, 128'(ov[i]), 128'd0);
      chk("pulse_ready", i, 128'(ir[i]), 128'd1);
    end

    // reset asserted at the second BUSY edge
    in_data = V2_IN; in_bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_valid", i, 128'(ov[i]), 128'd0);
      chk("midrst_data", i, od[i], 128'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("postrst_ready", i, 128'(ir[i]), 128'd1);
    run(V1_IN, 1'b0, 1'b0);
    check_result("postrst", V1_OUT, 1'b0);
    release_out();

`ifdef INV_MIX_COLUMNS_EN
    run(V1_OUT, 1'b0, 1'b1);
    check_result("inv_col", V1_IN, 1'b0);
    release_out();
    for (int t = 0; t < 3; t++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run(x, 1'b0, 1'b0);
      y = od[0];
      release_out();
      run(y, 1'b0, 1'b1);
      check_result("roundtrip", x, 1'b0);
      release_out();
    end
    in_inverse = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- AES MixColumns round stage. Sits directly downstream of the combinational ShiftRows block and consumes its 128-bit state output.
- Processes COLS_PER_CYCLE columns per clock through shared GF(2^8) column datapaths.
- Uses valid/ready handshakes on both sides. Supports a per-transfer bypass so the final AES round, which has no MixColumns, passes through the same stage.

Parameters:
- COLS_PER_CYCLE, 1, number of columns mixed per cycle. Legal values 1, 2, 4; any other value is an elaboration error. Instantiates COLS_PER_CYCLE column units.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  in_data/in_bypass valid.
- in_ready  output  1  stage can accept a state this cycle.
- in_data  input  128  state; column c = bits [32c +: 32], row r of column c = bits [32c+8r +: 8].
- in_bypass  input  1  when 1, output = input unchanged (final round).
- out_valid  output  1  out_data holds a completed state.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  128  mixed state, same packing as in_data.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, column counter 0, working register 0, out_data 128'h0, out_valid 0, in_ready 0 during reset. Reset wins over every other event, including mid-BUSY and mid-DONE; a partially mixed state is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, capture in_data into the working register and clear the counter.
  - If in_bypass=1, go to DONE; otherwise go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, column units replace columns k..k+COLS_PER_CYCLE-1 of the working register with their mixed values, where k = counter*COLS_PER_CYCLE.
  - Counter increments each cycle. When the last column group is written, go to DONE.
  - BUSY lasts N = 4/COLS_PER_CYCLE cycles.
- DONE:
  - out_valid=1, out_data = working register, in_ready=0.
  - On out_ready=1, go to IDLE. out_valid drops in the next cycle.
  - While out_ready=0, out_data and out_valid are held stable (no change permitted).
- Latency, measured from the input handshake edge to the first cycle out_valid=1:
  - N+1 cycles normal: 5, 3 or 2 for COLS_PER_CYCLE = 1, 2, 4.
  - 1 cycle bypass.
- Throughput: one state per N+2 cycles with out_ready tied high. Back-to-back acceptance in DONE is not supported.
- in_valid while in_ready=0 is ignored. The upstream source holds the data.
- Column math, for a column of bytes a0..a3 (row order):
  - xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xt(x)^x.
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - All arithmetic is 8-bit GF(2^8); no carries, no width growth.
- Column units are purely combinational. Only the working register, counter and FSM state are sequential.

Optional Feature:
- Macro INV_MIX_COLUMNS_EN.
- Defined:
  - Adds port in_inverse (input, 1), captured with in_data on the input handshake.
  - When captured as 1 (and in_bypass=0), columns use InvMixColumns coefficients (0E,0B,0D,09 circulant), computed via repeated xt().
  - Latency and handshake are unchanged. in_bypass overrides in_inverse.
- Not defined: the port does not exist and only forward MixColumns is built.

Test Plan:
- Column 0 = 32'h455313DB (bytes db,13,53,45), all other columns 0, bypass 0, COLS_PER_CYCLE=1 -> out_data[31:0]=32'hBCA14D8E, other columns 0. out_valid rises exactly 5 cycles after the accept edge.
- All four columns loaded with f2 0a 22 5c / 01 01 01 01 / c6 c6 c6 c6 / 2d 26 31 4c, run at COLS_PER_CYCLE=1, 2 and 4 -> 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6 / 4d 7e bd f8 in every build. Latencies are 5, 3 and 2 cycles respectively.
- in_bypass=1 with arbitrary in_data -> out_data==in_data, out_valid 1 cycle after accept, no BUSY cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_data -> out_data and out_valid stable, in_ready=0. Then pulse out_ready for 1 cycle -> IDLE next cycle with in_ready=1.
- Reset mid-BUSY (rst_n=0 at the 2nd BUSY edge) -> next cycle out_valid=0, out_data=0. After release, in_ready=1 and a fresh vector produces the correct result.
- With INV_MIX_COLUMNS_EN: column 32'hBCA14D8E, in_inverse=1 -> 32'h455313DB. Then forward and inverse back-to-back on random states -> identity.
